itype_alu_arbiter: RTL and testbench
====================================

# itype_alu_arbiter

Shares one combinational I-type ALU (`I_type`) between two instruction requesters, e.g. two issue slots or two harts, on a single clock. Each cycle the block selects at most one valid request by round-robin. It decodes the immediate, checks that the instruction is a legal OP-IMM, and registers the ALU result into a one-entry output buffer with a valid/ready handshake. It sits between issue logic and register-file writeback.

## Interface
- `XLEN`, 32: datapath width; fixed at 32 because the shared ALU is 32-bit.
- `CNT_W`, 16: width of the per-requester grant counters.

- `clk` in 1: the only clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 holds a valid instruction.
- `req0_ready` out 1: requester 0 transfer accepted this cycle.
- `req0_instr` in 32: requester 0 instruction word.
- `req0_rs1` in 32: requester 0 rs1 operand value.
- `req1_valid`, `req1_ready`, `req1_instr`, `req1_rs1`: same as requester 0, for requester 1.
- `res_valid` out 1: output buffer holds a result.
- `res_ready` in 1: consumer accepts the result.
- `res_id` out 1: requester that produced the result.
- `res_rd` out 5: destination register, `instr[11:7]`.
- `res_data` out 32: ALU result; 0 when `res_err` is 1.
- `res_err` out 1: the instruction was an illegal OP-IMM.
- `grant_cnt0` out CNT_W: number of accepted requester-0 transfers; wraps at the top of the range.
- `grant_cnt1` out CNT_W: same for requester 1.

## Operation
- **Buffer free:** `buf_free = !res_valid || res_ready`.
- **Ready rule:** `reqN_ready = buf_free && reqN_valid && grant==N`. Ready never asserts for an idle requester.
- **Arbitration:**
  - Only requester N valid → grant N.
  - Both valid → grant the requester that was not granted last (`last_gnt` register).
  - `last_gnt` updates only on an accepted transfer.
  - Reset value `last_gnt=1`, so requester 0 wins the first contest.
- **Immediate:** `{{20{instr[31]}}, instr[31:20]}`, driven to the ALU together with the granted instruction and rs1.
- **Legality (`err`):**
  - `opcode != 7'b0010011` → illegal.
  - `funct3==001` with `instr[31:25] != 0` → illegal.
  - `funct3==101` with `instr[31:25]` not in {`0000000`, `0100000`} → illegal.
- **Capture on accept:**
  - `res_valid←1`, `res_id←grant`, `res_rd←instr[11:7]`, `res_err←err`.
  - `res_data←err ? 0 : alu_out`.
  - Increment `grant_cnt[grant]`.
- **Drain:** `res_valid && res_ready` with no new accept in the same cycle → `res_valid←0`. The other result fields hold their last values.
- **Simultaneous drain and accept:** the buffer is overwritten in the same cycle with no bubble, giving full throughput of one result per cycle.
- **Result semantics:** RISC-V RV32I OP-IMM. SLTI is signed, SLTIU is unsigned on the sign-extended immediate, and shifts use `imm[4:0]`.

## Timing
- **Latency:** 1 cycle from the accept edge to `res_valid`. The ALU path is combinational from the request inputs to the buffer D inputs.
- **Back-pressure:** while `res_valid && !res_ready`, every `reqN_ready` is 0. Buffer contents are stable until drained.
- **Requester hold rule:** a requester must hold `instr`/`rs1` stable while valid and not ready. Dropping valid before ready is allowed and is treated as a withdrawn request.
- **Reset values:** `res_valid=0`, `res_id=0`, `res_rd=0`, `res_data=0`, `res_err=0`, `grant_cnt0=0`, `grant_cnt1=0`, `last_gnt=1`.
- **Reset mid-operation:** `rst_n` low clears immediately, asynchronously, including a pending result, which is lost. The first accept is possible on the first rising edge after `rst_n` is released.
- **Counter wrap:** `2^CNT_W-1 + 1 → 0`, with no flag.

## Structure
- **Shared package `rv_pkg`:**
  - `OPC_OP_IMM=7'b0010011`.
  - funct3 enum `f3_imm_e` (ADDI, SLLI, SLTI, SLTIU, XORI, SRLI_SRAI, ORI, ANDI).
  - `imm_i()` sign-extension function.
- **Sub-module:** one instance of the existing `I_type` ALU. Arbitration, legality checking and the output buffer stay in this module.

## Test plan
- **Single accept:** req0 `addi x5,x1,-3` with rs1=10, consumer ready → `req0_ready`=1; next cycle `res_valid`=1, id=0, rd=5, data=7, err=0.
- **Contention:** both valid every cycle for 4 cycles with `res_ready`=1 → grants 0,1,0,1; `grant_cnt0`=`grant_cnt1`=2.
- **Back-pressure:** `res_ready`=0 for 3 cycles with a full buffer → both `reqN_ready`=0 and `res_*` stable. Then `res_ready`=1 with req1 valid → drain and accept in the same cycle, `res_valid` stays 1.
- **Illegal instructions:** req1 opcode `0110011` → res_err=1, data=0, rd echoed. `slli` with `instr[31:25]=0000001` → err=1.
- **Signed vs unsigned compare:** `slti` rs1=-1, imm=1 → data=1. `sltiu` rs1=1, imm=-1 (0xFFFFFFFF) → data=1.
- **Reset mid-operation:** assert `rst_n`=0 while `res_valid`=1 → `res_valid`=0 and counters=0 at once. After release, both requesters valid → requester 0 is granted first.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I OP-IMM definitions: opcode constant, funct3 encoding and
// I-type immediate sign extension.
package rv_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   typedef enum logic [2:0] {
      ADDI      = 3'b000,
      SLLI      = 3'b001,
      SLTI      = 3'b010,
      SLTIU     = 3'b011,
      XORI      = 3'b100,
      SRLI_SRAI = 3'b101,
      ORI       = 3'b110,
      ANDI      = 3'b111
   } f3_imm_e;

   // I-type immediate: instr[31:20] sign-extended to 32 bits.
   function automatic logic [31:0] imm_i(input logic [11:0] imm12);
      return {{20{imm12[11]}}, imm12};
   endfunction

endpackage

// File: rtl/itype_alu_arbiter_if.sv
// Request/result bundle for itype_alu_arbiter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. Ready is driven by the receiver and may depend combinationally on
// valid; the sender holds its payload stable while valid && !ready, but may
// drop valid before ready (withdrawn request).
interface itype_alu_arbiter_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [31:0]      req0_instr;
   logic [XLEN-1:0]  req0_rs1;
   logic             req1_valid;
   logic             req1_ready;
   logic [31:0]      req1_instr;
   logic [XLEN-1:0]  req1_rs1;
   logic             res_valid;
   logic             res_ready;
   logic             res_id;
   logic [4:0]       res_rd;
   logic [XLEN-1:0]  res_data;
   logic             res_err;
   logic [CNT_W-1:0] grant_cnt0;
   logic [CNT_W-1:0] grant_cnt1;

   // Requesters and result consumer side.
   modport master (
      output req0_valid, req0_instr, req0_rs1,
      output req1_valid, req1_instr, req1_rs1,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_id, res_rd, res_data, res_err,
      input  grant_cnt0, grant_cnt1
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_instr, req0_rs1,
      input  req1_valid, req1_instr, req1_rs1,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_id, res_rd, res_data, res_err,
      output grant_cnt0, grant_cnt1
   );
endinterface

// File: rtl/I_type.sv
// Combinational RV32I OP-IMM ALU. Shifts use imm[4:0]; arith selects SRAI
// over SRLI (instr[30]).
module I_type
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  f3_imm_e         funct3,
   input  logic            arith,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] alu_out
);

   // Operation select on funct3.
   always_comb begin
      alu_out = '0;
      case (funct3)
         ADDI:      alu_out = rs1 + imm;
         SLLI:      alu_out = rs1 << imm[4:0];
         SLTI:      alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(imm))};
         SLTIU:     alu_out = {{(XLEN-1){1'b0}}, (rs1 < imm)};
         XORI:      alu_out = rs1 ^ imm;
         SRLI_SRAI: begin
            if (arith) alu_out = $signed(rs1) >>> imm[4:0];
            else       alu_out = rs1 >> imm[4:0];
         end
         ORI:       alu_out = rs1 | imm;
         ANDI:      alu_out = rs1 & imm;
         default:   alu_out = '0;
      endcase
   end

endmodule

// File: rtl/itype_alu_arbiter.sv
// Round-robin sharing of one I-type ALU between two requesters, with a
// one-entry registered result buffer and per-requester grant counters.
module itype_alu_arbiter
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst_n,
   itype_alu_arbiter_if.slave bus
);

   logic             last_gnt;
   logic             grant;
   logic             buf_free;
   logic             accept;
   logic [31:0]      sel_instr;
   logic [XLEN-1:0]  sel_rs1;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  alu_out;
   f3_imm_e          funct3;
   logic [6:0]       funct7;
   logic             err;
   logic             unused_rs1_field;

   logic             res_valid_q;
   logic             res_id_q;
   logic [4:0]       res_rd_q;
   logic [XLEN-1:0]  res_data_q;
   logic             res_err_q;
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt1_q;

   // Arbitration: a lone requester wins; on contention the one not granted last wins.
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) grant = ~last_gnt;
      else if (bus.req1_valid)              grant = 1'b1;
   end

   assign buf_free       = !res_valid_q || bus.res_ready;
   assign accept         = buf_free && (bus.req0_valid || bus.req1_valid);
   assign bus.req0_ready = buf_free && bus.req0_valid && !grant;
   assign bus.req1_ready = buf_free && bus.req1_valid && grant;

   assign sel_instr = grant ? bus.req1_instr : bus.req0_instr;
   assign sel_rs1   = grant ? bus.req1_rs1   : bus.req0_rs1;
   assign imm       = imm_i(sel_instr[31:20]);
   assign funct3    = f3_imm_e'(sel_instr[14:12]);
   assign funct7    = sel_instr[31:25];

   // The rs1 register index is resolved by issue logic; only its value arrives here.
   assign unused_rs1_field = ^sel_instr[19:15];

   // Legality of the granted instruction as an OP-IMM.
   always_comb begin
      err = 1'b0;
      if (sel_instr[6:0] != OPC_OP_IMM)
         err = 1'b1;
      else if (funct3 == SLLI && funct7 != 7'b0000000)
         err = 1'b1;
      else if (funct3 == SRLI_SRAI && funct7 != 7'b0000000 && funct7 != 7'b0100000)
         err = 1'b1;
   end

   I_type #(.XLEN(XLEN)) u_alu (
      .funct3  (funct3),
      .arith   (sel_instr[30]),
      .rs1     (sel_rs1),
      .imm     (imm),
      .alu_out (alu_out)
   );

   // Result buffer, round-robin history and grant counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_id_q    <= 1'b0;
         res_rd_q    <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
         last_gnt    <= 1'b1;
      end else if (accept) begin
         res_valid_q <= 1'b1;
         res_id_q    <= grant;
         res_rd_q    <= sel_instr[11:7];
         res_err_q   <= err;
         res_data_q  <= err ? '0 : alu_out;
         last_gnt    <= grant;
         if (grant) cnt1_q <= cnt1_q + CNT_W'(1);
         else       cnt0_q <= cnt0_q + CNT_W'(1);
      end else if (res_valid_q && bus.res_ready) begin
         res_valid_q <= 1'b0;
      end
   end

   assign bus.res_valid  = res_valid_q;
   assign bus.res_id     = res_id_q;
   assign bus.res_rd     = res_rd_q;
   assign bus.res_data   = res_data_q;
   assign bus.res_err    = res_err_q;
   assign bus.grant_cnt0 = cnt0_q;
   assign bus.grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_itype_alu_arbiter.sv
// Directed bench for itype_alu_arbiter: reset values, single accepts,
// round-robin contention, back-pressure, illegal encodings, ALU corner
// cases and asynchronous reset mid-operation.
module tb_itype_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_cnt0 = 0;
   int exp_cnt1 = 0;

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   itype_alu_arbiter_if #(.XLEN(32), .CNT_W(16)) bus ();

   itype_alu_arbiter #(.XLEN(32), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1f,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
      return {imm12, rs1f, f3, rd, opc};
   endfunction

   // Present one instruction from a single requester, with the consumer ready,
   // and check the handshake and the captured result one cycle later.
   task automatic single(input string tag, input bit id, input logic [31:0] instr,
                         input logic [31:0] rs1, input logic [4:0] exp_rd,
                         input logic [31:0] exp_data, input bit exp_err);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_instr = instr; bus.req1_rs1 = rs1;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_instr = instr; bus.req0_rs1 = rs1;
      end
      #1;
      check({tag, "_rdy0"}, bus.req0_ready, !id);
      check({tag, "_rdy1"}, bus.req1_ready, id);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (id) exp_cnt1++; else exp_cnt0++;
      check({tag, "_valid"}, bus.res_valid, 1'b1);
      check({tag, "_id"},    bus.res_id, id);
      check({tag, "_rd"},    bus.res_rd, exp_rd);
      check({tag, "_data"},  bus.res_data, exp_data);
      check({tag, "_err"},   bus.res_err, exp_err);
      check({tag, "_cnt0"},  bus.grant_cnt0, exp_cnt0);
      check({tag, "_cnt1"},  bus.grant_cnt1, exp_cnt1);
   endtask

   // Directed sequence.
   initial begin
      rst_n          = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_instr = '0; bus.req0_rs1 = '0;
      bus.req1_valid = 1'b0; bus.req1_instr = '0; bus.req1_rs1 = '0;
      bus.res_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset values.
      check("rst_valid", bus.res_valid, 1'b0);
      check("rst_id",    bus.res_id, 1'b0);
      check("rst_rd",    bus.res_rd, 5'd0);
      check("rst_data",  bus.res_data, 32'd0);
      check("rst_err",   bus.res_err, 1'b0);
      check("rst_cnt0",  bus.grant_cnt0, 16'd0);
      check("rst_cnt1",  bus.grant_cnt1, 16'd0);

      rst_n         = 1'b1;
      bus.res_ready = 1'b1;

      // addi x5,x1,-3 with rs1=10 -> 7.
      single("addi", 1'b0, enc_i(12'hFFD, 5'd1, 3'b000, 5'd5, 7'h13), 32'd10, 5'd5, 32'd7, 1'b0);
      #1;
      check("idle_rdy0", bus.req0_ready, 1'b0);
      check("idle_rdy1", bus.req1_ready, 1'b0);

      // R-type opcode from requester 1 is illegal; rd still echoed.
      single("bad_opc", 1'b1, {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011},
             32'd123, 5'd7, 32'd0, 1'b1);

      // Contention: both valid for 4 cycles -> grants 0,1,0,1.
      bus.req0_instr = enc_i(12'd1, 5'd1, 3'b000, 5'd3, 7'h13); bus.req0_rs1 = 32'd100;
      bus.req1_instr = enc_i(12'd2, 5'd1, 3'b000, 5'd4, 7'h13); bus.req1_rs1 = 32'd200;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("cont_rdy0", bus.req0_ready, (k % 2) == 0);
         check("cont_rdy1", bus.req1_ready, (k % 2) == 1);
         @(posedge clk); #1;
         if ((k % 2) == 0) exp_cnt0++; else exp_cnt1++;
         check("cont_valid", bus.res_valid, 1'b1);
         check("cont_id",    bus.res_id, k % 2);
         check("cont_data",  bus.res_data, ((k % 2) == 0) ? 32'd101 : 32'd202);
         check("cont_rd",    bus.res_rd, ((k % 2) == 0) ? 5'd3 : 5'd4);
      end
      check("cont_cnt0", bus.grant_cnt0, exp_cnt0);
      check("cont_cnt1", bus.grant_cnt1, exp_cnt1);

      // Back-pressure: buffer full, consumer stalled, both requesters valid.
      bus.res_ready  = 1'b0;
      bus.req1_instr = enc_i(12'h0FF, 5'd1, 3'b100, 5'd9, 7'h13);
      bus.req1_rs1   = 32'h0000_0F0F;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_rdy0",  bus.req0_ready, 1'b0);
         check("bp_rdy1",  bus.req1_ready, 1'b0);
         check("bp_valid", bus.res_valid, 1'b1);
         check("bp_id",    bus.res_id, 1'b1);
         check("bp_rd",    bus.res_rd, 5'd4);
         check("bp_data",  bus.res_data, 32'd202);
         @(posedge clk);
      end
      #1;
      check("bp_cnt0", bus.grant_cnt0, exp_cnt0);
      check("bp_cnt1", bus.grant_cnt1, exp_cnt1);

      // Drain and accept on the same edge: xori 0x0F0F ^ 0x0FF.
      bus.res_ready  = 1'b1;
      bus.req0_valid = 1'b0;
      #1;
      check("da_rdy0", bus.req0_ready, 1'b0);
      check("da_rdy1", bus.req1_ready, 1'b1);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      exp_cnt1++;
      check("da_valid", bus.res_valid, 1'b1);
      check("da_id",    bus.res_id, 1'b1);
      check("da_rd",    bus.res_rd, 5'd9);
      check("da_data",  bus.res_data, 32'h0000_0FF0);
      check("da_cnt1",  bus.grant_cnt1, exp_cnt1);

      // Plain drain: valid drops, fields hold.
      @(posedge clk); #1;
      check("drain_valid", bus.res_valid, 1'b0);
      check("drain_data",  bus.res_data, 32'h0000_0FF0);
      check("drain_rd",    bus.res_rd, 5'd9);

      // Shift legality and ALU corner cases.
      single("slli_bad",  1'b0, {7'b0000001, 5'd3, 5'd1, 3'b001, 5'd6, 7'h13},
             32'd1, 5'd6, 32'd0, 1'b1);
      single("slli",      1'b1, {7'b0000000, 5'd4, 5'd1, 3'b001, 5'd6, 7'h13},
             32'd3, 5'd6, 32'h30, 1'b0);
      single("slti",      1'b1, enc_i(12'h001, 5'd1, 3'b010, 5'd10, 7'h13),
             32'hFFFF_FFFF, 5'd10, 32'd1, 1'b0);
      single("sltiu",     1'b0, enc_i(12'hFFF, 5'd1, 3'b011, 5'd11, 7'h13),
             32'd1, 5'd11, 32'd1, 1'b0);
      single("srai",      1'b1, {7'b0100000, 5'd4, 5'd1, 3'b101, 5'd12, 7'h13},
             32'h8000_0000, 5'd12, 32'hF800_0000, 1'b0);
      single("srli",      1'b0, {7'b0000000, 5'd4, 5'd1, 3'b101, 5'd13, 7'h13},
             32'h8000_0000, 5'd13, 32'h0800_0000, 1'b0);
      single("srli_bad",  1'b0, {7'b0000010, 5'd4, 5'd1, 3'b101, 5'd13, 7'h13},
             32'h8000_0000, 5'd13, 32'd0, 1'b1);
      single("andi",      1'b1, enc_i(12'h0F0, 5'd1, 3'b111, 5'd14, 7'h13),
             32'h1234_5678, 5'd14, 32'h0000_0070, 1'b0);

      // Reset while a result is pending.
      bus.res_ready  = 1'b0;
      bus.req0_instr = enc_i(12'd1, 5'd1, 3'b000, 5'd3, 7'h13); bus.req0_rs1 = 32'd100;
      bus.req1_instr = enc_i(12'd2, 5'd1, 3'b000, 5'd4, 7'h13); bus.req1_rs1 = 32'd200;
      bus.req0_valid = 1'b1;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      check("pre_rst_valid", bus.res_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      check("arst_valid", bus.res_valid, 1'b0);
      check("arst_data",  bus.res_data, 32'd0);
      check("arst_cnt0",  bus.grant_cnt0, 16'd0);
      check("arst_cnt1",  bus.grant_cnt1, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n          = 1'b1;
      bus.res_ready  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check("post_rst_rdy0", bus.req0_ready, 1'b1);
      check("post_rst_rdy1", bus.req1_ready, 1'b0);
      @(posedge clk); #1;
      check("post_rst_id",   bus.res_id, 1'b0);
      check("post_rst_data", bus.res_data, 32'd101);
      check("post_rst_cnt0", bus.grant_cnt0, 16'd1);
      check("post_rst_cnt1", bus.grant_cnt1, 16'd0);
      check("post_rst_rdy1b", bus.req1_ready, 1'b1);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("post_rst_id2",  bus.res_id, 1'b1);
      check("post_rst_data2", bus.res_data, 32'd202);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
